// File: rtl/range_pkg.sv
// range_pkg: shared definitions for the range sweeper / count scanner pair.
//   RAM_WORDS      - count entries produced by one sweep and scanned per run
//   RAM_ADDR_BITS  - entry index width
//   CNT_W          - width of one iteration count
//   SUM_W          - width of the run total; holds RAM_WORDS * (2**CNT_W - 1)
//   scan_state_t   - count_scanner FSM states
package range_pkg;
  localparam int RAM_WORDS     = 16;
  localparam int RAM_ADDR_BITS = 4;
  localparam int CNT_W         = 16;
  localparam int SUM_W         = CNT_W + RAM_ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_SETTLE, S_WAIT, S_ADDR, S_READ, S_EMIT, S_FINISH
  } scan_state_t;
endpackage

// File: rtl/count_scanner.sv
// count_scanner: launches the range sweeper on a host go, waits for it to fill
// its count RAM, then reads every entry back and streams (n, count) pairs over
// a valid/ready port while tracking the run's maximum count and total.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   go, base            - host start request and first number of the range
//   busy, done          - run in progress / one-cycle completion pulse
//   rgo, rstart         - sweeper launch strobe; start number, then RAM read address
//   rdone, rcount       - sweeper finished; registered RAM read data
//   out_valid/ready     - streamed entry handshake
//   out_n, out_count    - streamed number and its count
//   max_count, max_n    - largest count of the run and the number that produced it
//   sum                 - total of all counts in the run
module count_scanner #(
  parameter int RAM_WORDS     = range_pkg::RAM_WORDS,
  parameter int RAM_ADDR_BITS = range_pkg::RAM_ADDR_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        go,
  input  logic [31:0]                 base,
  output logic                        busy,
  output logic                        done,
  output logic                        rgo,
  output logic [31:0]                 rstart,
  input  logic                        rdone,
  input  logic [range_pkg::CNT_W-1:0] rcount,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_n,
  output logic [range_pkg::CNT_W-1:0] out_count,
  output logic [range_pkg::CNT_W-1:0] max_count,
  output logic [31:0]                 max_n,
  output logic [range_pkg::SUM_W-1:0] sum
);
  import range_pkg::*;

  localparam logic [RAM_ADDR_BITS-1:0] LAST = RAM_ADDR_BITS'(RAM_WORDS - 1);

  scan_state_t              state, nxt;
  logic [RAM_ADDR_BITS-1:0] idx;
  logic [31:0]              base_q;
  logic                     hs;

  assign hs = (state == S_EMIT) && out_ready;

  always_comb begin
    nxt       = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    rgo       = 1'b0;
    rstart    = '0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:   if (go) nxt = S_LAUNCH;
      S_LAUNCH: begin rgo = 1'b1; rstart = base_q; nxt = S_SETTLE; end
      // rdone still reflects the previous sweep here; the sweeper only
      // drops it after seeing this run's rgo.
      S_SETTLE: nxt = S_WAIT;
      S_WAIT:   if (rdone) nxt = S_ADDR;
      S_ADDR:   begin rstart = {{(32-RAM_ADDR_BITS){1'b0}}, idx}; nxt = S_READ; end
      S_READ:   begin rstart = {{(32-RAM_ADDR_BITS){1'b0}}, idx}; nxt = S_EMIT; end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) nxt = (idx == LAST) ? S_FINISH : S_ADDR;
      end
      S_FINISH: begin done = 1'b1; nxt = S_IDLE; end
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      base_q    <= '0;
      out_n     <= '0;
      out_count <= '0;
      max_count <= '0;
      max_n     <= '0;
      sum       <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && go) begin
        base_q    <= base;
        idx       <= '0;
        max_count <= '0;
        max_n     <= '0;
        sum       <= '0;
      end
      if (state == S_READ) begin
        out_count <= rcount;
        out_n     <= base_q + 32'(idx);
      end
      if (hs) begin
        sum <= sum + SUM_W'(out_count);
        // Strict compare keeps the lowest n among equal maxima; entry 0
        // always loads so a run of all-zero counts still reports base.
        if (idx == '0 || out_count > max_count) begin
          max_count <= out_count;
          max_n     <= out_n;
        end
        if (idx != LAST) idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_count_scanner.sv
module tb_count_scanner;
  logic        clk = 0, reset = 1, go = 0;
  logic [31:0] base = 0;
  logic        busy, done, rgo, rdone, out_valid, out_ready;
  logic [31:0] rstart, out_n, max_n;
  logic [15:0] rcount, out_count, max_count;
  logic [19:0] sum;

  count_scanner dut (
    .clk(clk), .reset(reset), .go(go), .base(base), .busy(busy), .done(done),
    .rgo(rgo), .rstart(rstart), .rdone(rdone), .rcount(rcount),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n),
    .out_count(out_count), .max_count(max_count), .max_n(max_n), .sum(sum)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] n; logic [15:0] c; } exp_t;
  exp_t q[$];

  int pass_cnt = 0, total_cnt = 0;
  int beats = 0, dones = 0, rgos = 0, stalls = 0;
  logic [31:0] got_n [16];
  logic [15:0] mem [16];
  bit stall_en = 0, kill = 0;
  int stall_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sweeper model: registered RAM read, rdone dropped on rgo and raised 20 cycles later.
  initial begin
    logic [3:0] a; logic g; int cnt;
    rdone = 0; rcount = 0; cnt = 0; a = 0; g = 0;
    forever begin
      @(negedge clk); a = rstart[3:0]; g = rgo;
      @(posedge clk); #1;
      rcount = mem[a];
      if (g) begin rdone = 0; cnt = 20; end
      else if (cnt > 0) begin cnt--; if (cnt == 0) rdone = 1; end
    end
  end

  // Consumer ready driver.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (kill) out_ready = 0;
      else if (stall_en && beats == 3 && stall_left > 0) begin
        out_ready = 0;
        if (out_valid) stall_left--;
      end else out_ready = 1;
    end
  end

  // Monitor: pops expectations on handshakes, checks stability while stalled.
  initial begin
    bit held; logic [31:0] hn; logic [15:0] hc; exp_t e;
    held = 0; hn = 0; hc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin held = 0; continue; end
      if (done) dones++;
      if (rgo) rgos++;
      if (out_valid && held) begin
        chk("stall_hold_n", out_n, hn);
        chk("stall_hold_count", {16'h0, out_count}, {16'h0, hc});
      end
      if (out_valid && !out_ready) begin held = 1; hn = out_n; hc = out_count; stalls++; end
      else held = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", out_n, 32'hxxxx_xxxx);
        else begin
          e = q.pop_front();
          chk($sformatf("beat%0d_n", beats), out_n, e.n);
          chk($sformatf("beat%0d_count", beats), {16'h0, out_count}, {16'h0, e.c});
        end
        if (beats < 16) got_n[beats] = out_n;
        beats++;
      end
    end
  end

  task automatic start_run(input logic [31:0] b, input bit all7);
    exp_t e;
    beats = 0; dones = 0; rgos = 0; stalls = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = all7 ? 16'd7 : 16'(3 * i);
      e.n = b + 32'(i); e.c = mem[i];
      q.push_back(e);
    end
    @(negedge clk); base = b; go = 1;
    @(negedge clk); go = 0;
  endtask

  task automatic finish_run(input logic [15:0] emax, input logic [31:0] en, input logic [19:0] esum);
    int t = 0;
    while (dones == 0 && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("done_timeout", 0, 1);
    repeat (5) @(negedge clk);
    chk("beats", beats, 16);
    chk("done_pulses", dones, 1);
    chk("rgo_pulses", rgos, 1);
    chk("queue_empty", q.size(), 0);
    chk("max_count", {16'h0, max_count}, {16'h0, emax});
    chk("max_n", max_n, en);
    chk("sum", {12'h0, sum}, {12'h0, esum});
    chk("busy_idle", {31'h0, busy}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 0);
    chk({tag, "_done"}, {31'h0, done}, 0);
    chk({tag, "_rgo"}, {31'h0, rgo}, 0);
    chk({tag, "_rstart"}, rstart, 0);
    chk({tag, "_valid"}, {31'h0, out_valid}, 0);
    chk({tag, "_out_n"}, out_n, 0);
    chk({tag, "_out_count"}, {16'h0, out_count}, 0);
    chk({tag, "_max_count"}, {16'h0, max_count}, 0);
    chk({tag, "_max_n"}, max_n, 0);
    chk({tag, "_sum"}, {12'h0, sum}, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 0;

    // counts 3*i from base 100
    start_run(32'd100, 0);
    finish_run(16'd45, 32'd115, 20'd360);

    // all counts equal: lowest n wins
    start_run(32'd5, 1);
    finish_run(16'd7, 32'd5, 20'd112);

    // backpressure at entry 3 for five cycles
    stall_en = 1; stall_left = 5;
    start_run(32'd200, 0);
    finish_run(16'd45, 32'd215, 20'd360);
    chk("stall_cycles", stalls, 5);
    stall_en = 0;

    // second go while sweeper is running is ignored
    start_run(32'd300, 0);
    repeat (5) @(negedge clk);
    go = 1; base = 32'd999;
    @(negedge clk); go = 0;
    finish_run(16'd45, 32'd315, 20'd360);
    repeat (30) @(negedge clk);
    chk("no_extra_rgo", rgos, 1);
    chk("no_extra_beats", beats, 16);

    // 32-bit wrap of base + index
    start_run(32'hFFFF_FFF8, 0);
    finish_run(16'd45, 32'd7, 20'd360);
    chk("wrap_entry8", got_n[8], 0);
    chk("wrap_entry15", got_n[15], 7);

    // reset while entry 6 is being offered
    start_run(32'd100, 0);
    t = 0;
    while (beats < 6 && t < 2000) begin @(negedge clk); t++; end
    kill = 1;
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    chk("entry6_offered", {31'h0, out_valid}, 1);
    chk("beats_before_reset", beats, 6);
    reset = 1;
    @(posedge clk); #1;
    chk_zero("midrun");
    @(negedge clk); reset = 0; kill = 0;
    q.delete();
    start_run(32'd100, 0);
    finish_run(16'd45, 32'd115, 20'd360);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
